// File: rtl/waterfall_pkg.sv
// Shared types and constants for the waterfall spectrogram renderer.
// Colormap encodings, fixed colours and the sx/sy-to-rgb latency helper.
package waterfall_pkg;

    typedef enum logic [1:0] {
        CMAP_RED  = 2'd0,
        CMAP_GRAY = 2'd1,
        CMAP_HEAT = 2'd2,
        CMAP_INV  = 2'd3
    } cmap_e;

    localparam logic [23:0] BG_RGB_DEF = 24'h00002D;
    localparam logic [23:0] GRID_RGB   = 24'h404040;

    localparam int GRID_BIN_STEP = 32;
    localparam int GRID_ROW_STEP = 10;

    // Three address stages plus RAM latency plus one colour stage.
    function automatic int pipe_latency(input int rd_latency);
        return 4 + rd_latency;
    endfunction

endpackage

// File: rtl/waterfall_renderer_if.sv
// Read bus between the renderer and the banked FFT history RAM.
// The renderer is the master; the RAM mux drives data_rd back.
interface waterfall_renderer_if #(
    parameter int DATA_WIDTH     = 4,
    parameter int NO_BANKS       = 4,
    parameter int RAM_ADDR_WIDTH = 12
);
    logic                      rd_en;
    logic [NO_BANKS-1:0]       bank_rd;
    logic [RAM_ADDR_WIDTH-1:0] addr_rd;
    logic [DATA_WIDTH-1:0]     data_rd;

    modport master (
        output rd_en,
        output bank_rd,
        output addr_rd,
        input  data_rd
    );

    modport slave (
        input  rd_en,
        input  bank_rd,
        input  addr_rd,
        output data_rd
    );
endinterface

// File: rtl/delayShiftRegister.sv
// Fixed-depth delay line used to align sync and pixel flags with the
// address/RAM/colour pipeline. Synchronous active-high flush.
module delayShiftRegister #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // Shift one slot per clock
    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Delay registers, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/waterfall_colormap.sv
// Colour stage: expands a magnitude sample to 8-bit intensity and maps it
// through the frame's colormap. Grid override only with WATERFALL_GRID_EN.
module waterfall_colormap
    import waterfall_pkg::*;
#(
    parameter int          DATA_WIDTH = 4,
    parameter logic [23:0] BG         = BG_RGB_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  cmap_e                 cmap,
    input  logic                  in_box,
`ifdef WATERFALL_GRID_EN
    input  logic                  grid,
`endif
    output logic [23:0]           rgb
);
    logic [7:0]  inten;
    logic [23:0] col;
    logic [23:0] rgb_d;
    logic [23:0] rgb_q;

    // Replicate the sample MSB-first into 8 bits, then apply the colormap
    always_comb begin
        for (int b = 0; b < 8; b++) begin
            inten[7-b] = data[DATA_WIDTH-1-(b % DATA_WIDTH)];
        end
        col = '0;
        unique case (cmap)
            CMAP_RED:  col = {inten, 8'h00, 8'h00};
            CMAP_GRAY: col = {inten, inten, inten};
            CMAP_HEAT: begin
                if (inten[7]) begin
                    col = {8'hFF, inten[6:0], 1'b0, 8'h00};
                end else begin
                    col = {inten[6:0], 1'b0, 8'h00, 8'h00};
                end
            end
            CMAP_INV:  col = {~inten, ~inten, ~inten};
        endcase
        rgb_d = in_box ? col : BG;
`ifdef WATERFALL_GRID_EN
        if (in_box && grid) begin
            rgb_d = GRID_RGB;
        end
`endif
    end

    // Registered pixel colour
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;
endmodule

// File: rtl/waterfall_renderer.sv
// Spectrogram pixel renderer: raster box -> FFT history bank/address ->
// colormap. Optional grid overlay when WATERFALL_GRID_EN is defined.
module waterfall_renderer
    import waterfall_pkg::*;
#(
    parameter int          DATA_WIDTH     = 4,
    parameter int          COORDW         = 16,
    parameter int          FFT_BINS       = 256,
    parameter int          NO_FFTS        = 50,
    parameter int          RAM_ADDR_WIDTH = 12,
    parameter int          NO_BANKS       = 4,
    parameter int          BOX_X0         = 0,
    parameter int          BOX_Y0         = 0,
    parameter int          X_SHIFT        = 1,
    parameter int          Y_SHIFT        = 3,
    parameter int          RD_LATENCY     = 2,
    parameter logic [23:0] BG_RGB         = BG_RGB_DEF
) (
    input  logic                       hdmi_clk,
    input  logic                       reset,
    input  logic [COORDW-1:0]          sx,
    input  logic [COORDW-1:0]          sy,
    input  logic [2:0]                 hve_in,
    input  logic [$clog2(NO_FFTS)-1:0] OLDEST_FFT_IDX,
    input  logic [1:0]                 cmap_sel,
    waterfall_renderer_if.master       ram,
    output logic [23:0]                rgb,
    output logic [2:0]                 hve
);
    localparam int IDXW  = $clog2(NO_FFTS);
    localparam int BINW  = $clog2(FFT_BINS);
    localparam int BOX_W = FFT_BINS << X_SHIFT;
    localparam int BOX_H = NO_FFTS << Y_SHIFT;
    localparam int LAT   = pipe_latency(RD_LATENCY);
`ifdef WATERFALL_GRID_EN
    localparam int FLW   = 2;
`else
    localparam int FLW   = 1;
`endif

    logic [IDXW-1:0] idx_d, idx_q;
    cmap_e           cmap_d, cmap_q;

    logic            a1_in_box_d, a1_in_box_q;
    logic [BINW-1:0] a1_bin_d, a1_bin_q;
    logic [IDXW-1:0] a1_r_d, a1_r_q;

    logic            a2_in_box_d, a2_in_box_q;
    logic [BINW-1:0] a2_bin_d, a2_bin_q;
    logic [IDXW-1:0] a2_row_d, a2_row_q;

    logic                      rd_en_d, rd_en_q;
    logic [NO_BANKS-1:0]       bank_d, bank_q;
    logic [RAM_ADDR_WIDTH-1:0] addr_d, addr_q;

    logic [31:0]     dx, dy, lin;
    logic [IDXW:0]   row_sum;
    logic            in_box_c;
    logic [FLW-1:0]  flags_in, flags_dly;

    // Latch scroll index and colormap once per frame at the raster origin
    always_comb begin
        idx_d  = idx_q;
        cmap_d = cmap_q;
        if (sx == '0 && sy == '0) begin
            idx_d  = (32'(OLDEST_FFT_IDX) < 32'(NO_FFTS)) ? OLDEST_FFT_IDX : '0;
            cmap_d = cmap_e'(cmap_sel);
        end
    end

    // Address pipeline: box test, ring-row wrap, linear -> bank/address
    always_comb begin
        dx       = 32'(sx) - 32'(BOX_X0);
        dy       = 32'(sy) - 32'(BOX_Y0);
        in_box_c = (dx < 32'(BOX_W)) && (dy < 32'(BOX_H));

        a1_in_box_d = in_box_c;
        a1_bin_d    = BINW'(dx >> X_SHIFT);
        a1_r_d      = IDXW'(dy >> Y_SHIFT);

        row_sum = (IDXW+1)'(idx_q) + (IDXW+1)'(a1_r_q);
        if (row_sum >= (IDXW+1)'(NO_FFTS)) begin
            row_sum = row_sum - (IDXW+1)'(NO_FFTS);
        end
        a2_in_box_d = a1_in_box_q;
        a2_bin_d    = a1_bin_q;
        a2_row_d    = IDXW'(row_sum);

        lin     = 32'({a2_row_q, a2_bin_q});
        rd_en_d = a2_in_box_q;
        addr_d  = a2_in_box_q ? lin[RAM_ADDR_WIDTH-1:0] : addr_q;
        bank_d  = '0;
        for (int b = 0; b < NO_BANKS; b++) begin
            if (a2_in_box_q && ((lin >> RAM_ADDR_WIDTH) == 32'(b))) begin
                bank_d[b] = 1'b1;
            end
        end
    end

    // Pixel flags travelling alongside the pipeline
    always_comb begin
`ifdef WATERFALL_GRID_EN
        flags_in = {((32'(a1_bin_d) % GRID_BIN_STEP) == 0) ||
                    ((32'(a1_r_d) % GRID_ROW_STEP) == 0),
                    in_box_c};
`else
        flags_in = in_box_c;
`endif
    end

    // Frame latch and address stage registers
    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            idx_q       <= '0;
            cmap_q      <= CMAP_RED;
            a1_in_box_q <= 1'b0;
            a1_bin_q    <= '0;
            a1_r_q      <= '0;
            a2_in_box_q <= 1'b0;
            a2_bin_q    <= '0;
            a2_row_q    <= '0;
            rd_en_q     <= 1'b0;
            bank_q      <= '0;
            addr_q      <= '0;
        end else begin
            idx_q       <= idx_d;
            cmap_q      <= cmap_d;
            a1_in_box_q <= a1_in_box_d;
            a1_bin_q    <= a1_bin_d;
            a1_r_q      <= a1_r_d;
            a2_in_box_q <= a2_in_box_d;
            a2_bin_q    <= a2_bin_d;
            a2_row_q    <= a2_row_d;
            rd_en_q     <= rd_en_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
        end
    end

    assign ram.rd_en   = rd_en_q;
    assign ram.bank_rd = bank_q;
    assign ram.addr_rd = addr_q;

    delayShiftRegister #(.WIDTH(3), .DEPTH(LAT)) u_hve_dly (
        .clk   (hdmi_clk),
        .reset (reset),
        .din   (hve_in),
        .dout  (hve)
    );

    // Flags arrive at the colour stage together with data_rd
    delayShiftRegister #(.WIDTH(FLW), .DEPTH(LAT-1)) u_flag_dly (
        .clk   (hdmi_clk),
        .reset (reset),
        .din   (flags_in),
        .dout  (flags_dly)
    );

    waterfall_colormap #(.DATA_WIDTH(DATA_WIDTH), .BG(BG_RGB)) u_cmap (
        .clk    (hdmi_clk),
        .reset  (reset),
        .data   (ram.data_rd),
        .cmap   (cmap_q),
        .in_box (flags_dly[0]),
`ifdef WATERFALL_GRID_EN
        .grid   (flags_dly[FLW-1]),
`endif
        .rgb    (rgb)
    );
endmodule

// File: tb/tb_waterfall_renderer.sv
// Randomised bench for waterfall_renderer against a pixel-level model.
// Includes a banked RAM model with two-cycle read latency.
module tb_waterfall_renderer;
    import waterfall_pkg::*;

    localparam logic [23:0] BG = 24'h00002D;

    typedef struct {
        logic        rd_en;
        logic [3:0]  bank;
        logic [11:0] addr;
        logic [23:0] rgb;
        logic [2:0]  hve;
        bit          rst;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sx, sy;
    logic [2:0]  hve_in;
    logic [5:0]  idx_in;
    logic [1:0]  cmap_sel;
    logic [23:0] rgb;
    logic [2:0]  hve;
    logic [3:0]  p1;

    int   total = 0;
    int   bad   = 0;
    int   n     = 0;
    int   m_idx, m_cmap, m_last;
    exp_t hist [8192];

    always #5 clk = ~clk;

    waterfall_renderer_if #(
        .DATA_WIDTH(4), .NO_BANKS(4), .RAM_ADDR_WIDTH(12)
    ) ram_if ();

    waterfall_renderer dut (
        .hdmi_clk       (clk),
        .reset          (reset),
        .sx             (sx),
        .sy             (sy),
        .hve_in         (hve_in),
        .OLDEST_FFT_IDX (idx_in),
        .cmap_sel       (cmap_sel),
        .ram            (ram_if),
        .rgb            (rgb),
        .hve            (hve)
    );

    function automatic logic [3:0] mem_f(int b, int a);
        return 4'((a ^ (a >> 4) ^ (b * 5)) & 15);
    endfunction

    function automatic int oh2idx(logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    // Banked RAM: address registered, then data registered
    always @(posedge clk) begin
        p1             <= mem_f(oh2idx(ram_if.bank_rd), int'(ram_if.addr_rd));
        ram_if.data_rd <= p1;
    end

    function automatic logic [23:0] colour(int d, int cm);
        int i;
        i = d * 17;
        case (cm)
            0: return 24'(i << 16);
            1: return 24'(i * 32'h010101);
            2: begin
                if (i < 128) return 24'((2 * i) << 16);
                return 24'((255 << 16) | ((2 * (i - 128)) << 8));
            end
            default: return 24'((255 - i) * 32'h010101);
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    task automatic step(int x, int y, int idx, int cm, bit rst);
        exp_t e;
        int   bin, r, row, lin;
        logic [2:0] h;
        h        = 3'($urandom_range(0, 7));
        sx       = 16'(x);
        sy       = 16'(y);
        hve_in   = h;
        idx_in   = 6'(idx);
        cmap_sel = 2'(cm);
        reset    = rst;
        e = '{rd_en: 1'b0, bank: 4'h0, addr: 12'h0, rgb: BG, hve: 3'h0, rst: 1'b1};
        if (rst) begin
            m_idx = 0; m_cmap = 0; m_last = 0;
            for (int k = n - 5; k < n; k++) if (k >= 0) hist[k] = e;
        end else begin
            if (x == 0 && y == 0) begin
                m_idx  = (idx < 50) ? idx : 0;
                m_cmap = cm;
            end
            e.rst = 1'b0;
            e.hve = h;
            if (x < 512 && y < 400) begin
                bin    = x / 2;
                r      = y / 8;
                row    = (m_idx + r) % 50;
                lin    = row * 256 + bin;
                m_last = lin % 4096;
                e.rd_en = 1'b1;
                e.bank  = 4'(1 << (lin / 4096));
                e.rgb   = colour(int'(mem_f(lin / 4096, m_last)), m_cmap);
`ifdef WATERFALL_GRID_EN
                if (bin % 32 == 0 || r % 10 == 0) e.rgb = 24'h404040;
`endif
            end
            e.addr = 12'(m_last);
        end
        hist[n] = e;
        @(posedge clk);
        #1;
        if (rst) begin
            check("rst_rgb", 32'(rgb), 32'h0);
            check("rst_hve", 32'(hve), 32'h0);
            check("rst_rden", 32'(ram_if.rd_en), 32'h0);
            check("rst_bank", 32'(ram_if.bank_rd), 32'h0);
            check("rst_addr", 32'(ram_if.addr_rd), 32'h0);
        end else begin
            if (n >= 2) begin
                check("rd_en", 32'(ram_if.rd_en), 32'(hist[n-2].rd_en));
                check("bank_rd", 32'(ram_if.bank_rd), 32'(hist[n-2].bank));
                check("addr_rd", 32'(ram_if.addr_rd), 32'(hist[n-2].addr));
            end
            if (n >= 5) begin
                check("rgb", 32'(rgb), 32'(hist[n-5].rgb));
                check("hve", 32'(hve), 32'(hist[n-5].hve));
            end
        end
        n++;
    endtask

    initial begin
        int idx, cm, x, y;
        p1             = '0;
        ram_if.data_rd = '0;
        m_idx = 0; m_cmap = 0; m_last = 0;
        for (int i = 0; i < 6; i++) step(700, 500, 0, 0, 1'b1);
        for (int f = 0; f < 12; f++) begin
            if (f == 0)      idx = 0;
            else if (f == 1) idx = 49;
            else if (f == 2) idx = 55;
            else             idx = int'($urandom_range(0, 63));
            cm = (f < 4) ? f : int'($urandom_range(0, 3));
            step(0, 0, idx, cm, 1'b0);
            if (f == 0) begin
                step(10, 17, 7, 3, 1'b0);
                step(511, 399, 20, 1, 1'b0);
                step(600, 50, 3, 2, 1'b0);
                step(512, 10, 0, 0, 1'b0);
                step(10, 400, 0, 0, 1'b0);
            end
            if (f == 1) step(10, 17, 0, 0, 1'b0);
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(0, 9) < 7) begin
                    x = int'($urandom_range(0, 511));
                    y = int'($urandom_range(0, 399));
                end else begin
                    x = int'($urandom_range(0, 799));
                    y = int'($urandom_range(0, 599));
                end
                if (x == 0 && y == 0) x = 1;
                step(x, y, int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 3)), (f == 6 && k == 75));
            end
            for (int j = 0; j < 8; j++) step(700 + j, 500, 0, 0, 1'b0);
        end
        for (int j = 0; j < 8; j++) step(720 + j, 520, 0, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
